// File: rtl/matrix_input_loader.sv
// rtl/matrix_input_loader.sv - byte-stream matrix loader feeding multi-matrix storage
// Parses row/col header, writes elements row-major, zero-fills short streams.
module matrix_input_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SIZE   = 5,
  parameter int MATRIX_NUM = 8,
  parameter int IDX_W      = 3,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      matrix_idx,
  output logic [2:0]            store_row,
  output logic [2:0]            store_col,
  output logic [ADDR_W-1:0]     wr_addr_in,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code,
  output logic [IDX_W-1:0]      next_idx
);

  localparam logic [2:0] S_ROW   = 3'd0;
  localparam logic [2:0] S_COL   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]        state, state_n;
  logic [2:0]        row_q, col_q;
  logic [ADDR_W-1:0] total, cnt, cnt_inc;
  logic              accept, dim_ok, last_elem;

  assign accept    = in_valid && in_ready;
  assign dim_ok    = (in_data != '0) && (in_data <= DATA_WIDTH'(MAX_SIZE));
  assign cnt_inc   = cnt + ADDR_W'(1);
  assign last_elem = (cnt_inc == total);

  always_comb begin
    state_n = state;
    case (state)
      S_ROW: begin
        if (accept) begin
          if (dim_ok)        state_n = S_COL;
          else if (!in_last) state_n = S_DRAIN;
        end
      end
      S_COL: begin
        if (accept) begin
          if (!dim_ok)      state_n = in_last ? S_ROW : S_DRAIN;
          else if (in_last) state_n = S_ROW;
          else              state_n = S_DATA;
        end
      end
      S_DATA: begin
        // Reaching total wins over in_last: a full stream never zero-fills.
        if (accept) begin
          if (last_elem)    state_n = S_DONE;
          else if (in_last) state_n = S_FILL;
        end
      end
      S_FILL:  if (last_elem) state_n = S_DONE;
      S_DONE:  state_n = S_ROW;
      S_DRAIN: if (accept && in_last) state_n = S_ROW;
      default: state_n = S_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_ROW;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      matrix_idx <= '0;
      store_row  <= 3'd1;
      store_col  <= 3'd1;
      wr_addr_in <= '0;
      wr_data    <= '0;
      err_code   <= 2'd0;
      next_idx   <= '0;
      row_q      <= 3'd1;
      col_q      <= 3'd1;
      total      <= '0;
      cnt        <= '0;
    end else begin
      // in_ready and busy are registered from the next state so they track it exactly.
      state     <= state_n;
      in_ready  <= (state_n != S_FILL) && (state_n != S_DONE);
      busy      <= (state_n != S_ROW);
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        S_ROW: begin
          if (accept) begin
            if (dim_ok) begin
              row_q <= in_data[2:0];
            end else begin
              err_code <= 2'd1;
              load_err <= in_last;
            end
          end
        end
        S_COL: begin
          if (accept) begin
            if (!dim_ok) begin
              err_code <= 2'd1;
              load_err <= in_last;
            end else if (in_last) begin
              err_code <= 2'd2;
              load_err <= 1'b1;
            end else begin
              col_q      <= in_data[2:0];
              total      <= ADDR_W'(row_q) * ADDR_W'(in_data[2:0]);
              cnt        <= '0;
              matrix_idx <= next_idx;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            wr_en      <= 1'b1;
            wr_addr_in <= cnt;
            wr_data    <= in_data;
            store_row  <= row_q;
            store_col  <= col_q;
            cnt        <= cnt_inc;
          end
        end
        S_FILL: begin
          wr_en      <= 1'b1;
          wr_addr_in <= cnt;
          wr_data    <= '0;
          store_row  <= row_q;
          store_col  <= col_q;
          cnt        <= cnt_inc;
        end
        S_DONE: begin
          load_done <= 1'b1;
          next_idx  <= (next_idx == IDX_W'(MATRIX_NUM - 1)) ? '0 : next_idx + IDX_W'(1);
        end
        S_DRAIN: if (accept && in_last) load_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_input_loader.sv
// tb/tb_matrix_input_loader.sv - self-checking bench for matrix_input_loader
// Drives byte streams and compares storage writes against a stream-level model.
module tb_matrix_input_loader;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, wr_en, busy, load_done, load_err;
  logic [2:0] matrix_idx, store_row, store_col, next_idx;
  logic [5:0] wr_addr_in;
  logic [7:0] wr_data;
  logic [1:0] err_code;

  matrix_input_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .matrix_idx(matrix_idx), .store_row(store_row),
    .store_col(store_col), .wr_addr_in(wr_addr_in), .wr_data(wr_data), .busy(busy),
    .load_done(load_done), .load_err(load_err), .err_code(err_code), .next_idx(next_idx)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0]  stim[$];
  logic [22:0] exp_wr[$], got_wr[$];
  int          got_cyc[$];
  logic        got_rdy[$];
  int          n_done, n_err, done_cyc, both = 0, exp_done, exp_err, m_next = 0;
  logic [1:0]  exp_code = 2'd0;
  bit          gap_en = 1'b0, end_last = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      got_wr.push_back({matrix_idx, store_row, store_col, wr_addr_in, wr_data});
      got_cyc.push_back(cyc);
      got_rdy.push_back(in_ready);
    end
    if (load_done) begin n_done++; done_cyc = cyc; end
    if (load_err) n_err++;
    if (load_done && load_err) both++;
  end

  // Stream-level reference: what one complete stream should produce.
  function automatic void model_stream();
    int r, c, tot;
    logic [7:0] d;
    r = stim[0];
    if (r < 1 || r > 5) begin exp_err++; exp_code = 2'd1; return; end
    c = stim[1];
    if (c < 1 || c > 5) begin exp_err++; exp_code = 2'd1; return; end
    if (stim.size() == 2) begin exp_err++; exp_code = 2'd2; return; end
    tot = r * c;
    for (int k = 0; k < tot; k++) begin
      d = (k + 2 < stim.size()) ? stim[k+2] : 8'd0;
      exp_wr.push_back({3'(m_next), 3'(r), 3'(c), 6'(k), d});
    end
    exp_done++;
    m_next = (m_next + 1) % 8;
  endfunction

  task automatic clear();
    got_wr.delete(); got_cyc.delete(); got_rdy.delete(); exp_wr.delete(); stim.delete();
    n_done = 0; n_err = 0; exp_done = 0; exp_err = 0; done_cyc = -1;
  endtask

  task automatic send_stim();
    int budget;
    for (int i = 0; i < stim.size(); i++) begin
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 1'b0; end
      @(negedge clk);
      in_valid = 1'b1; in_data = stim[i]; in_last = end_last && (i == stim.size() - 1);
      budget = 0;
      while (!in_ready && budget < 100) begin @(negedge clk); budget++; end
      if (budget >= 100) begin
        checks++; errors++;
        $display("FAIL handshake_timeout byte=%0d in_ready=%0b required=1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_quiet();
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({in_ready, wr_en, busy, load_done, load_err} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got=%b required=00000", {in_ready, wr_en, busy, load_done, load_err}); end
    checks++; if ({store_row, store_col} !== 6'o11)
      begin errors++; $display("FAIL reset_store got=%0d,%0d required=1,1", store_row, store_col); end
    checks++; if ({matrix_idx, wr_addr_in, wr_data, err_code, next_idx} !== '0)
      begin errors++; $display("FAIL reset_values idx=%0d addr=%0d data=%0d code=%0d next=%0d required all 0", matrix_idx, wr_addr_in, wr_data, err_code, next_idx); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    clear();
    stim = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== 6) begin errors++; $display("FAIL basic_wr_count got=%0d required=6", got_wr.size()); end
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++; if (i >= got_wr.size() || got_wr[i] !== exp_wr[i])
        begin errors++; $display("FAIL basic_wr[%0d] got=%h required=%h", i, (i < got_wr.size()) ? got_wr[i] : 23'h0, exp_wr[i]); end
    end
    checks++; if (n_done !== 1 || n_err !== 0) begin errors++; $display("FAIL basic_done done=%0d err=%0d required=1,0", n_done, n_err); end
    checks++; if (got_cyc.size() > 0 && done_cyc !== got_cyc[got_cyc.size()-1] + 1)
      begin errors++; $display("FAIL basic_done_timing got=%0d required=%0d", done_cyc, got_cyc[got_cyc.size()-1] + 1); end
    checks++; if (next_idx !== 3'd1) begin errors++; $display("FAIL basic_next_idx got=%0d required=1", next_idx); end
  endtask

  task automatic test_fill();
    clear();
    stim = '{8'd2, 8'd2, 8'd9, 8'd7};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== exp_wr.size()) begin errors++; $display("FAIL fill_wr_count got=%0d required=%0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++; if (i >= got_wr.size() || got_wr[i] !== exp_wr[i])
        begin errors++; $display("FAIL fill_wr[%0d] got=%h required=%h", i, (i < got_wr.size()) ? got_wr[i] : 23'h0, exp_wr[i]); end
    end
    if (got_wr.size() == 4) begin
      checks++; if (got_cyc[3] - got_cyc[0] !== 3) begin errors++; $display("FAIL fill_consecutive span=%0d required=3", got_cyc[3] - got_cyc[0]); end
      checks++; if (got_rdy[2] !== 1'b0 || got_rdy[3] !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b%b required=00", got_rdy[2], got_rdy[3]); end
      checks++; if (done_cyc !== got_cyc[3] + 1) begin errors++; $display("FAIL fill_done_timing got=%0d required=%0d", done_cyc, got_cyc[3] + 1); end
    end
    checks++; if (next_idx !== 3'(m_next)) begin errors++; $display("FAIL fill_next_idx got=%0d required=%0d", next_idx, m_next); end
  endtask

  task automatic test_bad_dim();
    clear();
    stim = '{8'd6, 8'd2, 8'd5, 8'd5};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== 0 || n_done !== 0) begin errors++; $display("FAIL bad_dim_writes got=%0d done=%0d required=0,0", got_wr.size(), n_done); end
    checks++; if (n_err !== 1 || err_code !== 2'd1) begin errors++; $display("FAIL bad_dim_err got=%0d code=%0d required=1,1", n_err, err_code); end
    checks++; if (next_idx !== 3'(m_next)) begin errors++; $display("FAIL bad_dim_next_idx got=%0d required=%0d", next_idx, m_next); end
    clear();
    stim = '{8'd1, 8'd1, 8'd8};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== 1 || got_wr[0] !== exp_wr[0])
      begin errors++; $display("FAIL after_err_load count=%0d got=%h required=%h", got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 23'h0, exp_wr[0]); end
  endtask

  task automatic test_trunc();
    clear();
    stim = '{8'd3, 8'd4};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== 0 || n_err !== 1 || err_code !== 2'd2)
      begin errors++; $display("FAIL trunc writes=%0d err=%0d code=%0d required=0,1,2", got_wr.size(), n_err, err_code); end
  endtask

  task automatic test_reset_mid();
    clear();
    stim = '{8'd3, 8'd3, 8'd11, 8'd22, 8'd33};
    for (int k = 0; k < 3; k++) exp_wr.push_back({3'(m_next), 3'd3, 3'd3, 6'(k), stim[k+2]});
    end_last = 1'b0;
    send_stim();
    end_last = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({wr_en, in_ready, busy, next_idx, matrix_idx, err_code, store_row} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 3'd1})
      begin errors++; $display("FAIL mid_reset_outputs wr=%b rdy=%b busy=%b next=%0d idx=%0d code=%0d row=%0d", wr_en, in_ready, busy, next_idx, matrix_idx, err_code, store_row); end
    rst_n = 1'b1; m_next = 0; exp_code = 2'd0;
    wait_quiet();
    checks++; if (got_wr.size() !== 3) begin errors++; $display("FAIL mid_reset_wr_count got=%0d required=3", got_wr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= got_wr.size() || got_wr[i] !== exp_wr[i])
        begin errors++; $display("FAIL mid_reset_wr[%0d] got=%h required=%h", i, (i < got_wr.size()) ? got_wr[i] : 23'h0, exp_wr[i]); end
    end
    clear();
    stim = '{8'd1, 8'd1, 8'd77};
    model_stream(); send_stim(); wait_quiet();
    checks++; if (got_wr.size() !== 1 || got_wr[0][22:20] !== 3'd0)
      begin errors++; $display("FAIL mid_reset_next_load count=%0d idx=%0d required=1,0", got_wr.size(), (got_wr.size() > 0) ? got_wr[0][22:20] : 3'd7); end
  endtask

  task automatic test_back_to_back();
    gap_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      clear();
      stim = '{8'd1, 8'd1, 8'($urandom_range(0, 255))};
      model_stream(); send_stim(); wait_quiet();
      checks++; if (got_wr.size() !== 1 || got_wr[0] !== exp_wr[0])
        begin errors++; $display("FAIL b2b[%0d] count=%0d got=%h required=%h", n, got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 23'h0, exp_wr[0]); end
    end
    checks++; if (next_idx !== 3'(m_next)) begin errors++; $display("FAIL b2b_wrap next=%0d required=%0d", next_idx, m_next); end
  endtask

  task automatic test_random();
    int r, c, n;
    for (int s = 0; s < 14; s++) begin
      clear();
      r = $urandom_range(0, 6); c = $urandom_range(0, 6);
      stim.push_back(8'(r)); stim.push_back(8'(c));
      if (r >= 1 && r <= 5 && c >= 1 && c <= 5) begin
        n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, r * c);
      end else begin
        n = $urandom_range(0, 3);
      end
      for (int k = 0; k < n; k++) stim.push_back(8'($urandom_range(0, 255)));
      model_stream(); send_stim(); wait_quiet();
      checks++; if (got_wr.size() !== exp_wr.size()) begin errors++; $display("FAIL rand[%0d]_wr_count got=%0d required=%0d", s, got_wr.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++; if (i >= got_wr.size() || got_wr[i] !== exp_wr[i])
          begin errors++; $display("FAIL rand[%0d]_wr[%0d] got=%h required=%h", s, i, (i < got_wr.size()) ? got_wr[i] : 23'h0, exp_wr[i]); end
      end
      checks++; if (n_done !== exp_done || n_err !== exp_err || err_code !== exp_code || next_idx !== 3'(m_next))
        begin errors++; $display("FAIL rand[%0d]_status done=%0d err=%0d code=%0d next=%0d required=%0d,%0d,%0d,%0d", s, n_done, n_err, err_code, next_idx, exp_done, exp_err, exp_code, m_next); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_bad_dim();
    test_trunc();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++; if (both !== 0) begin errors++; $display("FAIL done_and_err_together got=%0d required=0", both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
